// File: rtl/comms_core_dispatcher.sv
// Dispatches decoded TitanComms host commands onto the core's single-port req/ack
// register interface; owns bound addresses and holds READ/STREAM read-back data.
module comms_core_dispatcher #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int VALUE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic [7:0]               cmd_instr,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [VALUE_WIDTH-1:0]   cmd_value,
    output logic                     cmd_ready,
    output logic                     cmd_dropped,
    output logic                     core_req,
    output logic                     core_we,
    output logic [ADDRESS_WIDTH-1:0] core_addr,
    output logic [VALUE_WIDTH-1:0]   core_wdata,
    input  logic                     core_ack,
    input  logic [VALUE_WIDTH-1:0]   core_rdata,
    output logic [VALUE_WIDTH-1:0]   read_value,
    output logic [VALUE_WIDTH-1:0]   stream_value,
    output logic [ADDRESS_WIDTH-1:0] interrupt_addr,
    output logic                     err_timeout
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_WRITE          = 8'h01;
    localparam logic [7:0] OP_READ           = 8'h02;
    localparam logic [7:0] OP_BIND_READ      = 8'h03;
    localparam logic [7:0] OP_BIND_WRITE     = 8'h04;
    localparam logic [7:0] OP_STREAM         = 8'h06;
    localparam logic [7:0] OP_BIND_INTERRUPT = 8'h07;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] ST_WR = 3'd3;
    localparam logic [2:0] ST_RD = 3'd4;

    logic [2:0]               state_r, state_s;
    logic                     cmd_ready_r, cmd_ready_s;
    logic                     cmd_dropped_r, cmd_dropped_s;
    logic                     core_req_r, core_req_s;
    logic                     core_we_r, core_we_s;
    logic [ADDRESS_WIDTH-1:0] core_addr_r, core_addr_s;
    logic [VALUE_WIDTH-1:0]   core_wdata_r, core_wdata_s;
    logic [VALUE_WIDTH-1:0]   read_value_r, read_value_s;
    logic [VALUE_WIDTH-1:0]   stream_value_r, stream_value_s;
    logic [ADDRESS_WIDTH-1:0] irq_addr_r, irq_addr_s;
    logic [ADDRESS_WIDTH-1:0] bind_rd_r, bind_rd_s;
    logic [ADDRESS_WIDTH-1:0] bind_wr_r, bind_wr_s;
    logic                     err_r, err_s;
    logic [CW-1:0]            cnt_r, cnt_s;
    logic                     accept_s, ack_s, expire_s;

    assign cmd_ready      = cmd_ready_r;
    assign cmd_dropped    = cmd_dropped_r;
    assign core_req       = core_req_r;
    assign core_we        = core_we_r;
    assign core_addr      = core_addr_r;
    assign core_wdata     = core_wdata_r;
    assign read_value     = read_value_r;
    assign stream_value   = stream_value_r;
    assign interrupt_addr = irq_addr_r;
    assign err_timeout    = err_r;

    // Next-state logic: command decode, handshake completion and ack timeout.
    always_comb begin
        state_s        = state_r;
        core_req_s     = core_req_r;
        core_we_s      = core_we_r;
        core_addr_s    = core_addr_r;
        core_wdata_s   = core_wdata_r;
        read_value_s   = read_value_r;
        stream_value_s = stream_value_r;
        irq_addr_s     = irq_addr_r;
        bind_rd_s      = bind_rd_r;
        bind_wr_s      = bind_wr_r;
        err_s          = 1'b0;
        accept_s       = cmd_valid & cmd_ready_r;
        cmd_dropped_s  = cmd_valid & ~cmd_ready_r;
        ack_s          = core_req_r & core_ack;
        // Counter holds the number of completed request cycles of the current transfer.
        expire_s       = core_req_r & ~core_ack & (cnt_r == CW'(TIMEOUT_CYCLES - 1));
        if (core_req_r) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = {CW{1'b0}};
        end
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (cmd_instr)
                        OP_WRITE: begin
                            state_s      = WRITE;
                            core_req_s   = 1'b1;
                            core_we_s    = 1'b1;
                            core_addr_s  = cmd_addr;
                            core_wdata_s = cmd_value;
                        end
                        OP_READ: begin
                            state_s     = READ;
                            core_req_s  = 1'b1;
                            core_we_s   = 1'b0;
                            core_addr_s = cmd_addr;
                        end
                        OP_STREAM: begin
                            state_s      = ST_WR;
                            core_req_s   = 1'b1;
                            core_we_s    = 1'b1;
                            core_addr_s  = bind_wr_r;
                            core_wdata_s = cmd_value;
                        end
                        OP_BIND_READ:      bind_rd_s  = cmd_addr;
                        OP_BIND_WRITE:     bind_wr_s  = cmd_addr;
                        OP_BIND_INTERRUPT: irq_addr_s = cmd_addr;
                        default:           state_s    = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE, READ, ST_WR: begin
                if (ack_s) begin
                    core_req_s = 1'b0;
                    if (state_r == READ) begin
                        read_value_s = core_rdata;
                        state_s      = IDLE;
                    end else if (state_r == ST_WR) begin
                        // Read-back request reissues after a one-cycle gap from ST_RD.
                        state_s     = ST_RD;
                        core_we_s   = 1'b0;
                        core_addr_s = bind_rd_r;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (expire_s) begin
                    core_req_s = 1'b0;
                    err_s      = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RD: begin
                if (!core_req_r) begin
                    core_req_s = 1'b1;
                end else if (ack_s) begin
                    core_req_s     = 1'b0;
                    stream_value_s = core_rdata;
                    state_s        = IDLE;
                end else if (expire_s) begin
                    core_req_s = 1'b0;
                    err_s      = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s = ST_RD;
                end
            end
            default: begin
                state_s    = IDLE;
                core_req_s = 1'b0;
            end
        endcase
        cmd_ready_s = (state_r == IDLE) && (state_s == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cmd_ready_r    <= 1'b1;
            cmd_dropped_r  <= 1'b0;
            core_req_r     <= 1'b0;
            core_we_r      <= 1'b0;
            core_addr_r    <= {ADDRESS_WIDTH{1'b0}};
            core_wdata_r   <= {VALUE_WIDTH{1'b0}};
            read_value_r   <= {VALUE_WIDTH{1'b0}};
            stream_value_r <= {VALUE_WIDTH{1'b0}};
            irq_addr_r     <= {ADDRESS_WIDTH{1'b0}};
            bind_rd_r      <= {ADDRESS_WIDTH{1'b0}};
            bind_wr_r      <= {ADDRESS_WIDTH{1'b0}};
            err_r          <= 1'b0;
            cnt_r          <= {CW{1'b0}};
        end else begin
            state_r        <= state_s;
            cmd_ready_r    <= cmd_ready_s;
            cmd_dropped_r  <= cmd_dropped_s;
            core_req_r     <= core_req_s;
            core_we_r      <= core_we_s;
            core_addr_r    <= core_addr_s;
            core_wdata_r   <= core_wdata_s;
            read_value_r   <= read_value_s;
            stream_value_r <= stream_value_s;
            irq_addr_r     <= irq_addr_s;
            bind_rd_r      <= bind_rd_s;
            bind_wr_r      <= bind_wr_s;
            err_r          <= err_s;
            cnt_r          <= cnt_s;
        end
    end
endmodule

// File: tb/tb_comms_core_dispatcher.sv
// Self-checking bench for comms_core_dispatcher: transaction-level model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_comms_core_dispatcher;
    localparam int AW  = 24;
    localparam int VW  = 32;
    localparam int TMO = 4;

    localparam logic [7:0] OP_WRITE = 8'h01, OP_READ = 8'h02, OP_BIND_READ = 8'h03;
    localparam logic [7:0] OP_BIND_WRITE = 8'h04, OP_TRANSFER = 8'h05, OP_STREAM = 8'h06;
    localparam logic [7:0] OP_BIND_INTERRUPT = 8'h07;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd_instr = 8'h00;
    logic [AW-1:0] cmd_addr = '0;
    logic [VW-1:0] cmd_value = '0;
    logic          cmd_ready, cmd_dropped, core_req, core_we, err_timeout;
    logic [AW-1:0] core_addr, interrupt_addr;
    logic [VW-1:0] core_wdata, read_value, stream_value;
    logic          core_ack = 1'b0;
    logic [VW-1:0] core_rdata = '0;

    comms_core_dispatcher #(.ADDRESS_WIDTH(AW), .VALUE_WIDTH(VW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_instr(cmd_instr),
        .cmd_addr(cmd_addr), .cmd_value(cmd_value), .cmd_ready(cmd_ready),
        .cmd_dropped(cmd_dropped), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
        .core_rdata(core_rdata), .read_value(read_value), .stream_value(stream_value),
        .interrupt_addr(interrupt_addr), .err_timeout(err_timeout));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30) $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Core responder knobs
    bit ack_en = 1'b1;
    int ack_delay = 0;
    bit stray_ack = 1'b0;

    initial begin
        int wait_n = 0;
        bit prev_req = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (core_req) begin
                wait_n = prev_req ? wait_n + 1 : 0;
                core_ack = ack_en && (wait_n == ack_delay);
            end else begin
                core_ack = stray_ack;
            end
            prev_req = core_req;
        end
    end

    // Transaction-level model
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
        bit            to_stream;
    } txn_t;
    txn_t q[$];
    int cyc = 0;
    int m_req_at, m_ready_at, m_drop_at, m_err_at;
    logic [VW-1:0] m_read, m_stream;
    logic [AW-1:0] m_bwr, m_brd, m_irq;
    int n_err = 0, n_drop = 0, n_rise = 0;
    bit req_prev = 1'b0;

    initial begin
        bit exp_ready, exp_req;
        int n;
        txn_t t;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (!rst_n) begin
                q.delete();
                m_ready_at = 0; m_drop_at = -1; m_err_at = -1; m_req_at = 0;
                m_read = '0; m_stream = '0; m_bwr = '0; m_brd = '0; m_irq = '0;
                chk("rst_req", {31'b0, core_req}, 32'd0);
                chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
                chk("rst_err", {31'b0, err_timeout}, 32'd0);
                chk("rst_read_value", read_value, 32'd0);
            end else begin
                exp_ready = (q.size() == 0) && (cyc >= m_ready_at);
                exp_req   = (q.size() != 0) && (cyc >= m_req_at);
                chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_ready});
                chk("core_req", {31'b0, core_req}, {31'b0, exp_req});
                chk("cmd_dropped", {31'b0, cmd_dropped}, {31'b0, m_drop_at == cyc});
                chk("err_timeout", {31'b0, err_timeout}, {31'b0, m_err_at == cyc});
                chk("read_value", read_value, m_read);
                chk("stream_value", stream_value, m_stream);
                chk("interrupt_addr", {8'b0, interrupt_addr}, {8'b0, m_irq});
                if (exp_req) begin
                    chk("core_we", {31'b0, core_we}, {31'b0, q[0].we});
                    chk("core_addr", {8'b0, core_addr}, {8'b0, q[0].addr});
                    if (q[0].we) chk("core_wdata", core_wdata, q[0].data);
                end
                if (err_timeout) n_err++;
                if (cmd_dropped) n_drop++;
                if (core_req && !req_prev) n_rise++;
                req_prev = core_req;
                // advance the model with this cycle's inputs
                if (cmd_valid && !exp_ready) m_drop_at = cyc + 1;
                if (exp_req) begin
                    n = cyc - m_req_at + 1;
                    if (core_ack) begin
                        t = q.pop_front();
                        if (!t.we) begin
                            if (t.to_stream) m_stream = core_rdata;
                            else m_read = core_rdata;
                        end
                        if (q.size() != 0) m_req_at = cyc + 2;
                        else m_ready_at = cyc + 2;
                    end else if (n == TMO) begin
                        q.delete();
                        m_err_at = cyc + 1;
                        m_ready_at = cyc + 2;
                    end
                end
                if (cmd_valid && exp_ready) begin
                    m_req_at = cyc + 1;
                    case (cmd_instr)
                        OP_WRITE:  q.push_back('{1'b1, cmd_addr, cmd_value, 1'b0});
                        OP_READ:   q.push_back('{1'b0, cmd_addr, '0, 1'b0});
                        OP_STREAM: begin
                            q.push_back('{1'b1, m_bwr, cmd_value, 1'b0});
                            q.push_back('{1'b0, m_brd, '0, 1'b1});
                        end
                        OP_BIND_READ:      m_brd = cmd_addr;
                        OP_BIND_WRITE:     m_bwr = cmd_addr;
                        OP_BIND_INTERRUPT: m_irq = cmd_addr;
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic send(input logic [7:0] op, input logic [AW-1:0] a, input logic [VW-1:0] v);
        @(negedge clk); #1;
        cmd_valid = 1'b1; cmd_instr = op; cmd_addr = a; cmd_value = v;
    endtask

    task automatic release_cmd();
        @(negedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #3;
            if (cmd_ready && !core_req) begin ok = 1'b1; break; end
        end
        chk({nm, "_idle_timeout"}, {31'b0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int lat;
        int rises0, drops0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("lit_reset_ready", {31'b0, cmd_ready}, 32'd1);
        chk("lit_reset_req", {31'b0, core_req}, 32'd0);

        // 1: write with two wait cycles
        ack_delay = 2;
        send(OP_WRITE, 24'h000010, 32'hDEADBEEF); release_cmd();
        wait_idle("t1");
        chk("lit_t1_err", n_err, 32'd0);

        // zero-wait write: ready returns 3 cycles after accept
        ack_delay = 0;
        send(OP_WRITE, 24'h000014, 32'h00000001); release_cmd();
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            lat++;
            if (cmd_ready) break;
        end
        chk("lit_latency", lat + 1, 32'd3);

        // 2: read
        ack_delay = 1; core_rdata = 32'h12345678;
        send(OP_READ, 24'h000020, 32'h0); release_cmd();
        wait_idle("t2");
        chk("lit_t2_read_value", read_value, 32'h12345678);

        // 3: back-to-back binds then stream
        ack_delay = 0; core_rdata = 32'hCAFEF00D;
        send(OP_BIND_WRITE, 24'h000040, 32'h0);
        send(OP_BIND_READ, 24'h000044, 32'h0);
        send(OP_STREAM, 24'h0, 32'hA5A5A5A5); release_cmd();
        #2;
        chk("lit_t3_wr_addr", {8'b0, core_addr}, 32'h00000040);
        wait_idle("t3");
        chk("lit_t3_stream_value", stream_value, 32'hCAFEF00D);
        send(OP_BIND_INTERRUPT, 24'h123456, 32'h0); release_cmd();
        #2;
        chk("lit_irq", {8'b0, interrupt_addr}, 32'h00123456);

        // ignored opcodes and stray ack while idle
        stray_ack = 1'b1;
        send(OP_TRANSFER, 24'h000099, 32'h11111111);
        send(8'hFF, 24'h000099, 32'h22222222); release_cmd();
        repeat (3) @(negedge clk);
        #1 stray_ack = 1'b0;

        // 4: read timeout, then ack exactly on the expiring cycle
        ack_en = 1'b0; core_rdata = 32'h55555555;
        send(OP_READ, 24'h000020, 32'h0); release_cmd();
        wait_idle("t4");
        chk("lit_t4_err_count", n_err, 32'd1);
        chk("lit_t4_read_kept", read_value, 32'h12345678);
        ack_en = 1'b1; ack_delay = TMO - 1; core_rdata = 32'h0BADC0DE;
        send(OP_READ, 24'h000024, 32'h0); release_cmd();
        wait_idle("t4b");
        chk("lit_t4b_read_value", read_value, 32'h0BADC0DE);
        chk("lit_t4b_err_count", n_err, 32'd1);

        // stream timing out in its write phase skips the read-back
        ack_en = 1'b0; rises0 = n_rise;
        send(OP_STREAM, 24'h0, 32'h77777777); release_cmd();
        wait_idle("t4c");
        chk("lit_t4c_err_count", n_err, 32'd2);
        chk("lit_t4c_rises", n_rise - rises0, 32'd1);
        chk("lit_t4c_stream_kept", stream_value, 32'hCAFEF00D);

        // 5: command during a pending write is dropped
        ack_en = 1'b1; ack_delay = 3; rises0 = n_rise; drops0 = n_drop;
        send(OP_WRITE, 24'h000050, 32'h0000BEEF); release_cmd();
        send(OP_READ, 24'h000060, 32'h0); release_cmd();
        wait_idle("t5");
        chk("lit_t5_drops", n_drop - drops0, 32'd1);
        chk("lit_t5_rises", n_rise - rises0, 32'd1);

        // 6: reset while the stream write is in flight
        ack_delay = 5; ack_en = 1'b0;
        send(OP_BIND_WRITE, 24'h000060, 32'h0);
        send(OP_STREAM, 24'h0, 32'h99999999); release_cmd();
        @(negedge clk); #1;
        chk("lit_t6_req_before", {31'b0, core_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("lit_t6_req_async", {31'b0, core_req}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        chk("lit_t6_no_strd", {31'b0, core_req}, 32'd0);
        chk("lit_t6_irq", {8'b0, interrupt_addr}, 32'h0);
        ack_en = 1'b1; ack_delay = 0; core_rdata = 32'h31415926;
        send(OP_STREAM, 24'h0, 32'h12121212); release_cmd();
        #2;
        chk("lit_t6_bound_wr_zero", {8'b0, core_addr}, 32'h0);
        wait_idle("t6");
        chk("lit_t6_stream_value", stream_value, 32'h31415926);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
